// File: rtl/core_types_pkg.sv
// Shared core widths, ALU op encodings and the alu_imm_pipeline stage records.
package core_types_pkg;

  // Core-wide widths
  localparam int LOG_PR_COUNT       = 7;
  localparam int LOG_ROB_ENTRIES    = 6;
  localparam int PRF_BANK_COUNT     = 4;
  localparam int LOG_PRF_BANK_COUNT = 2;

  // ALU op encodings {bit30, funct3}, shared with the reg-reg ALU
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1101;

  typedef logic [LOG_PR_COUNT-1:0]       pr_t;
  typedef logic [LOG_ROB_ENTRIES-1:0]    rob_t;
  typedef logic [LOG_PRF_BANK_COUNT-1:0] bank_t;

  // Operand-collect stage: the issued op plus the captured copy of A
  typedef struct packed {
    logic        valid;
    logic        first;         // first cycle in OC: forward data is on the bus now
    logic        a_saved;       // a_saved_data holds operand A
    logic [3:0]  op;
    logic [11:0] imm12;
    logic        a_forward;
    logic        a_is_zero;
    bank_t       a_bank;
    pr_t         dest_pr;
    rob_t        rob_index;
    logic [31:0] a_saved_data;
  } oc_stage_t;

  // Execute stage: op with a resolved operand A
  typedef struct packed {
    logic        valid;
    logic [3:0]  op;
    logic [11:0] imm12;
    logic [31:0] a;
    pr_t         dest_pr;
    rob_t        rob_index;
  } ex_stage_t;

  // Writeback stage: the result presented to the writeback arbiter
  typedef struct packed {
    logic        valid;
    logic [31:0] data;
    pr_t         dest_pr;
    rob_t        rob_index;
  } wb_stage_t;

  // Sign-extend a 12-bit immediate to 32 bits
  function automatic logic [31:0] sext12(input logic [11:0] v);
    return {{20{v[11]}}, v};
  endfunction

  // Bit30 only selects SRA over SRL; for every other funct3 it is dropped
  function automatic logic [3:0] alu_imm_norm_op(input logic [3:0] op);
    if (op[2:0] == ALU_SRL[2:0]) begin
      return op;
    end
    return {1'b0, op[2:0]};
  endfunction

endpackage

// File: rtl/alu_imm_core.sv
// Combinational RV32I OP-IMM datapath: result = op(A, sext(imm12)).
module alu_imm_core
  import core_types_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [11:0] imm12,
  output logic [31:0] result
);

  logic [31:0] imm;
  logic [4:0]  shamt;
  logic [3:0]  op_n;

  assign imm   = sext12(imm12);
  assign shamt = imm12[4:0];
  assign op_n  = alu_imm_norm_op(op);

  // Result select over the normalised op code
  always_comb begin
    result = '0;
    case (op_n)
      ALU_ADD:  result = a + imm;
      ALU_SLL:  result = a << shamt;
      ALU_SLT:  result = {31'b0, ($signed(a) < $signed(imm))};
      ALU_SLTU: result = {31'b0, (a < imm)};
      ALU_XOR:  result = a ^ imm;
      ALU_SRL:  result = a >> shamt;
      ALU_SRA:  result = $signed(a) >>> shamt;
      ALU_OR:   result = a | imm;
      ALU_AND:  result = a & imm;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/alu_imm_pipeline.sv
// ALU reg-imm execution pipeline: OC (operand collect) -> EX -> WB.
//
// Handshakes: a transfer happens on a rising CLK edge where valid & ready are
// both high. Ready is computed from the downstream drain in the same cycle, so
// a stage can refill in the cycle it empties. The producer holds its payload
// stable while valid & ~ready; ready never depends on the producer's valid.
module alu_imm_pipeline
  import core_types_pkg::*;
(
  input  logic                                CLK,
  input  logic                                nRST,
  input  logic                                issue_valid,
  input  logic [3:0]                          issue_op,
  input  logic [11:0]                         issue_imm12,
  input  logic                                issue_A_forward,
  input  logic                                issue_A_is_zero,
  input  logic [LOG_PRF_BANK_COUNT-1:0]       issue_A_bank,
  input  logic [LOG_PR_COUNT-1:0]             issue_dest_PR,
  input  logic [LOG_ROB_ENTRIES-1:0]          issue_ROB_index,
  output logic                                issue_ready,
  input  logic                                A_reg_read_ack,
  input  logic [31:0]                         A_reg_read_data,
  input  logic [PRF_BANK_COUNT-1:0][31:0]     WB_bus_data_by_bank,
  output logic                                WB_valid,
  output logic [31:0]                         WB_data,
  output logic [LOG_PR_COUNT-1:0]             WB_PR,
  output logic [LOG_ROB_ENTRIES-1:0]          WB_ROB_index,
  input  logic                                WB_ready
);

  oc_stage_t   oc_q, oc_d;
  ex_stage_t   ex_q, ex_d;
  wb_stage_t   wb_q, wb_d;

  logic [31:0] oc_operand;
  logic        oc_operand_available;
  logic        wb_ready_int;
  logic        ex_ready;
  logic        oc_advance;
  logic        issue_accept;
  logic        ex_advance;
  logic [31:0] ex_result;

  // Operand A source, highest priority first; forward data is only on the bus
  // during the first OC cycle, the PRF response is live whenever it is acked
  always_comb begin
    oc_operand           = '0;
    oc_operand_available = 1'b0;
    if (oc_q.a_is_zero) begin
      oc_operand           = '0;
      oc_operand_available = 1'b1;
    end else if (oc_q.a_forward && oc_q.first) begin
      oc_operand           = WB_bus_data_by_bank[oc_q.a_bank];
      oc_operand_available = 1'b1;
    end else if (A_reg_read_ack) begin
      oc_operand           = A_reg_read_data;
      oc_operand_available = 1'b1;
    end else if (oc_q.a_saved) begin
      oc_operand           = oc_q.a_saved_data;
      oc_operand_available = 1'b1;
    end
  end

  // Ready chain from the writeback arbiter back to the issue queue
  assign wb_ready_int = ~wb_q.valid | WB_ready;
  assign ex_ready     = ~ex_q.valid | wb_ready_int;
  assign oc_advance   = oc_q.valid & oc_operand_available & ex_ready;
  assign ex_advance   = ex_q.valid & wb_ready_int;
  assign issue_ready  = ~oc_q.valid | (oc_operand_available & ex_ready);
  assign issue_accept = issue_valid & issue_ready;

  // OC next state: load on accept, empty on advance, otherwise hold and keep
  // any available operand so a one-shot source (forward, ack) is not lost
  always_comb begin
    oc_d = oc_q;
    if (issue_accept) begin
      oc_d.valid     = 1'b1;
      oc_d.first     = 1'b1;
      oc_d.a_saved   = 1'b0;
      oc_d.op        = issue_op;
      oc_d.imm12     = issue_imm12;
      oc_d.a_forward = issue_A_forward;
      oc_d.a_is_zero = issue_A_is_zero;
      oc_d.a_bank    = issue_A_bank;
      oc_d.dest_pr   = issue_dest_PR;
      oc_d.rob_index = issue_ROB_index;
    end else if (oc_advance) begin
      oc_d.valid = 1'b0;
      oc_d.first = 1'b0;
    end else if (oc_q.valid) begin
      oc_d.first = 1'b0;
      if (oc_operand_available) begin
        oc_d.a_saved      = 1'b1;
        oc_d.a_saved_data = oc_operand;
      end
    end
  end

  // EX next state: take the op with its resolved operand from OC
  always_comb begin
    ex_d = ex_q;
    if (oc_advance) begin
      ex_d.valid     = 1'b1;
      ex_d.op        = oc_q.op;
      ex_d.imm12     = oc_q.imm12;
      ex_d.a         = oc_operand;
      ex_d.dest_pr   = oc_q.dest_pr;
      ex_d.rob_index = oc_q.rob_index;
    end else if (wb_ready_int) begin
      ex_d.valid = 1'b0;
    end
  end

  alu_imm_core u_alu_imm_core (
    .op     (ex_q.op),
    .a      (ex_q.a),
    .imm12  (ex_q.imm12),
    .result (ex_result)
  );

  // WB next state: register the EX result, hold it while the arbiter stalls
  always_comb begin
    wb_d = wb_q;
    if (ex_advance) begin
      wb_d.valid     = 1'b1;
      wb_d.data      = ex_result;
      wb_d.dest_pr   = ex_q.dest_pr;
      wb_d.rob_index = ex_q.rob_index;
    end else if (WB_ready) begin
      wb_d.valid = 1'b0;
    end
  end

  // Stage registers; reset discards every in-flight op immediately
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      oc_q <= '0;
      ex_q <= '0;
      wb_q <= '0;
    end else begin
      oc_q <= oc_d;
      ex_q <= ex_d;
      wb_q <= wb_d;
    end
  end

  assign WB_valid     = wb_q.valid;
  assign WB_data      = wb_q.data;
  assign WB_PR        = wb_q.dest_pr;
  assign WB_ROB_index = wb_q.rob_index;

endmodule

// File: tb/tb_alu_imm_pipeline.sv
// Self-checking bench for alu_imm_pipeline: directed scenarios plus a random
// phase, with an expected-result queue drained by an independent WB monitor.
module tb_alu_imm_pipeline;
  import core_types_pkg::*;

  localparam int EXP_W  = 32 + LOG_PR_COUNT + LOG_ROB_ENTRIES;
  localparam int K_ZERO = 0;
  localparam int K_FWD  = 1;
  localparam int K_PRF  = 2;

  logic                            CLK;
  logic                            nRST;
  logic                            issue_valid;
  logic [3:0]                      issue_op;
  logic [11:0]                     issue_imm12;
  logic                            issue_A_forward;
  logic                            issue_A_is_zero;
  logic [LOG_PRF_BANK_COUNT-1:0]   issue_A_bank;
  logic [LOG_PR_COUNT-1:0]         issue_dest_PR;
  logic [LOG_ROB_ENTRIES-1:0]      issue_ROB_index;
  logic                            issue_ready;
  logic                            A_reg_read_ack;
  logic [31:0]                     A_reg_read_data;
  logic [PRF_BANK_COUNT-1:0][31:0] WB_bus_data_by_bank;
  logic                            WB_valid;
  logic [31:0]                     WB_data;
  logic [LOG_PR_COUNT-1:0]         WB_PR;
  logic [LOG_ROB_ENTRIES-1:0]      WB_ROB_index;
  logic                            WB_ready;

  int tests_run;
  int tests_failed;
  logic [EXP_W-1:0] exp_q[$];

  // Stimulus state
  int          wb_mode;       // 0: always ready, 1: random, 2: stalled
  bit          fwd_pending;
  bank_t       fwd_bank;
  logic [31:0] fwd_data;
  bit          prf_pending;
  int          prf_delay;
  logic [31:0] prf_data;
  int          last_kind;
  int          offer_kind;
  logic [31:0] offer_a;
  int          offer_delay;

  // Monitor statistics
  int wb_fire_cnt;
  int wb_run;
  int wb_run_max;

  alu_imm_pipeline dut (
    .CLK                 (CLK),
    .nRST                (nRST),
    .issue_valid         (issue_valid),
    .issue_op            (issue_op),
    .issue_imm12         (issue_imm12),
    .issue_A_forward     (issue_A_forward),
    .issue_A_is_zero     (issue_A_is_zero),
    .issue_A_bank        (issue_A_bank),
    .issue_dest_PR       (issue_dest_PR),
    .issue_ROB_index     (issue_ROB_index),
    .issue_ready         (issue_ready),
    .A_reg_read_ack      (A_reg_read_ack),
    .A_reg_read_data     (A_reg_read_data),
    .WB_bus_data_by_bank (WB_bus_data_by_bank),
    .WB_valid            (WB_valid),
    .WB_data             (WB_data),
    .WB_PR               (WB_PR),
    .WB_ROB_index        (WB_ROB_index),
    .WB_ready            (WB_ready)
  );

  // ---------------- clock / reset / watchdog ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // RV32I OP-IMM semantics from plain arithmetic on the raw fields
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [11:0] imm12);
    logic [31:0] imm;
    int          sh;
    int          sa;
    int          si;
    imm = {{20{imm12[11]}}, imm12};
    sh  = int'(imm12[4:0]);
    sa  = int'(a);
    si  = int'(imm);
    case (op[2:0])
      3'd0: return a + imm;
      3'd1: return a << sh;
      3'd2: return (sa < si) ? 32'd1 : 32'd0;
      3'd3: return (a < imm) ? 32'd1 : 32'd0;
      3'd4: return a ^ imm;
      3'd5: begin
        if (op[3] && a[31]) return ~((~a) >> sh);
        return a >> sh;
      end
      3'd6: return a | imm;
      default: return a & imm;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard monitor ----------------
  logic [EXP_W-1:0] prev_out;
  bit               prev_stall;
  logic [EXP_W-1:0] mon_exp;

  always @(negedge CLK) begin
    if (!nRST) begin
      prev_stall = 1'b0;
      wb_run     = 0;
    end else begin
      if (prev_stall) begin
        check("wb_hold_valid", 64'(WB_valid), 64'd1);
        check("wb_hold_payload", 64'({WB_data, WB_PR, WB_ROB_index}), 64'(prev_out));
      end
      if (WB_valid) begin
        wb_run++;
        if (wb_run > wb_run_max) wb_run_max = wb_run;
      end else begin
        wb_run = 0;
      end
      if (WB_valid && WB_ready) begin
        wb_fire_cnt++;
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL wb_unexpected: got data %h pr %0d rob %0d, expected no writeback",
                   WB_data, WB_PR, WB_ROB_index);
        end else begin
          mon_exp = exp_q.pop_front();
          check("wb_result", 64'({WB_data, WB_PR, WB_ROB_index}), 64'(mon_exp));
        end
      end
      prev_stall = WB_valid && !WB_ready;
      prev_out   = {WB_data, WB_PR, WB_ROB_index};
    end
  end

  // ---------------- driver tasks ----------------
  // Per-cycle inputs, applied just after the rising edge
  task automatic apply_cycle_inputs();
    for (int b = 0; b < PRF_BANK_COUNT; b++) WB_bus_data_by_bank[b] = $urandom;
    if (fwd_pending) begin
      WB_bus_data_by_bank[fwd_bank] = fwd_data;
      fwd_pending = 1'b0;
    end
    if (prf_pending) begin
      if (prf_delay == 0) begin
        A_reg_read_ack  = 1'b1;
        A_reg_read_data = prf_data;
        prf_pending     = 1'b0;
      end else begin
        A_reg_read_ack  = 1'b0;
        A_reg_read_data = $urandom;
        prf_delay--;
      end
    end else if (last_kind == K_ZERO && $urandom_range(0, 3) == 0) begin
      // Stray ack while OC is empty or holds an x0 op: must be ignored
      A_reg_read_ack  = 1'b1;
      A_reg_read_data = $urandom;
    end else begin
      A_reg_read_ack  = 1'b0;
      A_reg_read_data = $urandom;
    end
    case (wb_mode)
      0:       WB_ready = 1'b1;
      1:       WB_ready = ($urandom_range(0, 9) < 7);
      default: WB_ready = 1'b0;
    endcase
  endtask

  task automatic randomize_idle_issue();
    issue_valid     = 1'b0;
    issue_op        = 4'($urandom);
    issue_imm12     = 12'($urandom);
    issue_A_forward = 1'($urandom);
    issue_A_is_zero = 1'($urandom);
    issue_A_bank    = LOG_PRF_BANK_COUNT'($urandom);
    issue_dest_PR   = LOG_PR_COUNT'($urandom);
    issue_ROB_index = LOG_ROB_ENTRIES'($urandom);
  endtask

  // One clock cycle: record an accepted issue, then drive the next cycle
  task automatic tick(output bit accepted);
    logic [31:0] a_eff;
    @(negedge CLK);
    accepted = issue_valid && issue_ready;
    if (accepted) begin
      a_eff = (offer_kind == K_ZERO) ? 32'd0 : offer_a;
      exp_q.push_back({ref_alu(issue_op, a_eff, issue_imm12), issue_dest_PR, issue_ROB_index});
      last_kind = offer_kind;
      if (offer_kind == K_FWD) begin
        fwd_pending = 1'b1;
        fwd_bank    = issue_A_bank;
        fwd_data    = offer_a;
      end
      if (offer_kind == K_PRF) begin
        prf_pending = 1'b1;
        prf_delay   = offer_delay;
        prf_data    = offer_a;
      end
    end
    @(posedge CLK);
    #1;
    apply_cycle_inputs();
    if (accepted) randomize_idle_issue();
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) tick(acc);
  endtask

  // Offer one op until accepted; waited = cycles the offer was held
  task automatic issue(input int kind, input logic [3:0] op, input logic [11:0] imm,
                       input logic [31:0] a, input int delay, input int bank, output int waited);
    bit acc = 1'b0;
    offer_kind      = kind;
    offer_a         = a;
    offer_delay     = delay;
    issue_valid     = 1'b1;
    issue_op        = op;
    issue_imm12     = imm;
    issue_A_is_zero = (kind == K_ZERO);
    issue_A_forward = (kind == K_FWD) || (kind == K_ZERO && $urandom_range(0, 1) == 1);
    issue_A_bank    = (bank < 0) ? LOG_PRF_BANK_COUNT'($urandom) : LOG_PRF_BANK_COUNT'(bank);
    issue_dest_PR   = LOG_PR_COUNT'($urandom);
    issue_ROB_index = LOG_ROB_ENTRIES'($urandom);
    waited = 0;
    while (!acc && waited < 200) begin
      tick(acc);
      waited++;
    end
    if (!acc) begin
      tests_run++;
      tests_failed++;
      $display("FAIL issue_timeout: got no accept in %0d cycles, expected accept", waited);
      randomize_idle_issue();
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int  w;
    int  kind;
    int  fires0;
    bit  acc;

    tests_run    = 0;
    tests_failed = 0;
    wb_mode      = 0;
    fwd_pending  = 1'b0;
    prf_pending  = 1'b0;
    prf_delay    = 0;
    last_kind    = K_ZERO;
    wb_fire_cnt  = 0;
    wb_run       = 0;
    wb_run_max   = 0;
    fwd_bank     = '0;
    fwd_data     = '0;
    prf_data     = '0;
    offer_kind   = K_ZERO;
    offer_a      = '0;
    offer_delay  = 0;
    nRST         = 1'b0;
    randomize_idle_issue();
    apply_cycle_inputs();
    repeat (3) @(posedge CLK);
    #1;

    // Reset state
    check("reset_wb_valid", 64'(WB_valid), 64'd0);
    check("reset_wb_data", 64'(WB_data), 64'd0);
    check("reset_wb_pr", 64'(WB_PR), 64'd0);
    check("reset_wb_rob", 64'(WB_ROB_index), 64'd0);
    check("reset_issue_ready", 64'(issue_ready), 64'd1);
    nRST = 1'b1;
    apply_cycle_inputs();

    // Zero-operand ADDI, result three cycles after accept
    issue(K_ZERO, 4'b0000, 12'hFFF, 32'h0, 0, -1, w);
    check("lat_n1_valid", 64'(WB_valid), 64'd0);
    tick(acc);
    check("lat_n2_valid", 64'(WB_valid), 64'd0);
    tick(acc);
    check("lat_n3_valid", 64'(WB_valid), 64'd1);
    check("lat_n3_data", 64'(WB_data), 64'hFFFF_FFFF);
    idle(3);

    // Forwarded SRAI from bank 1
    issue(K_FWD, 4'b1101, 12'h004, 32'h8000_0000, 0, 1, w);
    idle(2);
    check("fwd_srai_valid", 64'(WB_valid), 64'd1);
    check("fwd_srai_data", 64'(WB_data), 64'hF800_0000);
    idle(3);

    // SLTIU with a PRF ack three cycles late: issue blocked until the ack
    issue(K_PRF, 4'b0011, 12'h001, 32'h0, 3, -1, w);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("prf_wait_issue_ready", 64'(issue_ready), 64'd0);
      tick(acc);
    end
    #1;
    check("prf_ack_issue_ready", 64'(issue_ready), 64'd1);
    idle(2);
    check("prf_sltiu_data", 64'(WB_data), 64'd1);
    idle(3);

    // Backpressure with forwarded operands: 10+1, 10+2, 10+3 stay in order
    wb_mode  = 2;
    WB_ready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      issue(K_FWD, 4'b0000, 12'(i), 32'd10, 0, -1, w);
      check("bp_issue_wait", 64'(w), 64'd1);
    end
    for (int i = 0; i < 4; i++) begin
      #1;
      check("bp_issue_ready_low", 64'(issue_ready), 64'd0);
      tick(acc);
    end
    wb_mode  = 0;
    WB_ready = 1'b1;
    idle(8);

    // Throughput: 8 back-to-back x0 ops, never blocked, 8 WB cycles in a row
    wb_run_max = 0;
    for (int i = 0; i < 8; i++) begin
      issue(K_ZERO, 4'($urandom), 12'($urandom), 32'h0, 0, -1, w);
      check("tput_issue_wait", 64'(w), 64'd1);
    end
    idle(6);
    check("tput_wb_run", 64'(wb_run_max), 64'd8);

    // Random traffic with random backpressure and PRF latency
    wb_mode = 1;
    for (int i = 0; i < 300; i++) begin
      kind = $urandom_range(0, 2);
      issue(kind, 4'($urandom), 12'($urandom), $urandom, $urandom_range(0, 3), -1, w);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    wb_mode = 0;
    idle(20);
    check("random_drain_queue", 64'(exp_q.size()), 64'd0);

    // Reset with every stage full and an op still offered
    wb_mode  = 2;
    WB_ready = 1'b0;
    for (int i = 0; i < 3; i++) issue(K_ZERO, 4'($urandom), 12'($urandom), 32'h0, 0, -1, w);
    offer_kind      = K_ZERO;
    issue_valid     = 1'b1;
    issue_A_is_zero = 1'b1;
    tick(acc);
    check("full_no_accept", 64'(acc), 64'd0);
    check("full_wb_valid", 64'(WB_valid), 64'd1);
    #1;
    nRST = 1'b0;
    #1;
    check("midrst_wb_valid", 64'(WB_valid), 64'd0);
    check("midrst_issue_ready", 64'(issue_ready), 64'd1);
    exp_q.delete();
    fwd_pending = 1'b0;
    prf_pending = 1'b0;
    last_kind   = K_ZERO;
    randomize_idle_issue();
    idle(2);
    nRST    = 1'b1;
    wb_mode = 0;
    fires0  = wb_fire_cnt;
    #1;
    check("postrst_issue_ready", 64'(issue_ready), 64'd1);
    idle(10);
    check("postrst_no_stale_wb", 64'(wb_fire_cnt - fires0), 64'd0);
    issue(K_PRF, 4'b0110, 12'h0F0, 32'h1234_5600, 1, -1, w);
    idle(8);
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
